// File: rtl/cpu19_pkg.sv
// ============================================================================
// Module      : cpu19_pkg
// Description : Shared definitions for the cpu19 instruction sequencer:
//               opcode map, instruction field positions, sequencer states
//               and the opcode classifier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu19_pkg;

  // Instruction word and field positions
  localparam int c_instr_w  = 19;
  localparam int c_op_msb   = 18;
  localparam int c_op_lsb   = 14;
  localparam int c_rd_msb   = 13;
  localparam int c_rd_lsb   = 10;
  localparam int c_rs1_msb  = 9;
  localparam int c_rs1_lsb  = 6;
  localparam int c_rs2_msb  = 5;
  localparam int c_rs2_lsb  = 2;
  localparam int c_off_msb  = 5;
  localparam int c_off_lsb  = 0;

  // Opcode map
  localparam logic [4:0] c_op_add  = 5'b00000;
  localparam logic [4:0] c_op_sub  = 5'b00001;
  localparam logic [4:0] c_op_mul  = 5'b00010;
  localparam logic [4:0] c_op_div  = 5'b00011;
  localparam logic [4:0] c_op_inc  = 5'b00100;
  localparam logic [4:0] c_op_dec  = 5'b00101;
  localparam logic [4:0] c_op_and  = 5'b00110;
  localparam logic [4:0] c_op_or   = 5'b00111;
  localparam logic [4:0] c_op_xor  = 5'b01000;
  localparam logic [4:0] c_op_not  = 5'b01001;
  localparam logic [4:0] c_op_jmp  = 5'b01010;
  localparam logic [4:0] c_op_beq  = 5'b01011;
  localparam logic [4:0] c_op_bne  = 5'b01100;
  localparam logic [4:0] c_op_call = 5'b01101;
  localparam logic [4:0] c_op_ret  = 5'b01110;
  localparam logic [4:0] c_op_ld   = 5'b01111;
  localparam logic [4:0] c_op_st   = 5'b10000;
  localparam logic [4:0] c_op_enc  = 5'b10001;
  localparam logic [4:0] c_op_dcr  = 5'b10010;
  localparam logic [4:0] c_op_halt = 5'b11111;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_WAIT_EX = 3'd4,
    ST_MEM     = 3'd5,
    ST_HALTED  = 3'd6,
    ST_TRAP    = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_MULTI   = 3'd1,
    CLS_MEM     = 3'd2,
    CLS_CTRL    = 3'd3,
    CLS_HALT    = 3'd4,
    CLS_ILLEGAL = 3'd5
  } opclass_t;

  // Map an opcode onto the execution class the sequencer dispatches on
  function automatic opclass_t op_class(input logic [4:0] op);
    opclass_t cls;
    cls = CLS_ILLEGAL;
    case (op)
      c_op_add, c_op_sub, c_op_inc, c_op_dec,
      c_op_and, c_op_or, c_op_xor, c_op_not:   cls = CLS_ALU;
      c_op_mul, c_op_div, c_op_enc, c_op_dcr:  cls = CLS_MULTI;
      c_op_ld, c_op_st:                        cls = CLS_MEM;
      c_op_jmp, c_op_beq, c_op_bne,
      c_op_call, c_op_ret:                     cls = CLS_CTRL;
      c_op_halt:                               cls = CLS_HALT;
      default:                                 cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu19_ret_stack.sv
// ============================================================================
// Module      : cpu19_ret_stack
// Description : Return-address LIFO for CALL/RET. STACK_DEPTH entries of
//               PC_W bits; push writes above the top, pop discards the top.
//               Push on full and pop on empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu19_ret_stack #(
  parameter int PC_W        = 14,
  parameter int STACK_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [PC_W-1:0] i_push_data,
  output logic [PC_W-1:0] o_top,
  output logic            o_full,
  output logic            o_empty
);

  localparam int c_cnt_w = $clog2(STACK_DEPTH + 1);
  localparam int c_idx_w = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_W-1:0]    r_mem [STACK_DEPTH];
  logic [c_cnt_w-1:0] r_count;
  logic [c_idx_w-1:0] w_wr_idx;
  logic [c_idx_w-1:0] w_top_idx;

  assign w_wr_idx  = c_idx_w'(r_count);
  assign w_top_idx = c_idx_w'(r_count - 1'b1);
  assign o_full    = (r_count == c_cnt_w'(STACK_DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_top     = r_mem[w_top_idx];

  // Occupancy counter; only the count defines what is valid, so storage needs no reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_push && !o_full) begin
      r_count <= r_count + 1'b1;
    end else if (i_pop && !o_empty) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Entry storage written at the current count on a push
  always_ff @(posedge clk) begin
    if (i_push && !o_full) begin
      r_mem[w_wr_idx] <= i_push_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu19_seq.sv
// ============================================================================
// Module      : cpu19_seq
// Description : Instruction sequencer for the 19-bit cpu19 core. Owns the PC,
//               fetches over a req/ack port, decodes and issues ops to the
//               datapath, waits on multi-cycle units and data memory, and
//               resolves JMP/BEQ/BNE/CALL/RET.
//               Build option: CPU19_CALL_STACK_EN builds the return stack;
//               without it CALL and RET are illegal and trap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu19_seq
  import cpu19_pkg::*;
#(
  parameter int PC_W        = 14,
  parameter int STACK_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [18:0]     imem_rdata,
  output logic            issue_valid,
  output logic [4:0]      issue_op,
  output logic [3:0]      issue_rd,
  output logic [3:0]      issue_rs1,
  output logic [3:0]      issue_rs2,
  input  logic            ex_done,
  input  logic            cmp_eq,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            trap
);

  localparam int c_off_w = c_off_msb - c_off_lsb + 1;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [PC_W-1:0]        r_pc;
  logic [PC_W-1:0]        w_pc_next;
  logic [c_instr_w-1:0]   r_ir;
  logic                   w_ir_load;

  logic [4:0]             w_op;
  opclass_t               w_cls;
  logic                   w_illegal;
  logic [PC_W-1:0]        w_pc_inc;
  logic [PC_W-1:0]        w_target;
  logic [c_off_w-1:0]     w_off;
  logic [PC_W-1:0]        w_branch;

  logic                   w_push;
  logic                   w_pop;
  logic [PC_W-1:0]        w_stk_top;
  logic                   w_stk_full;
  logic                   w_stk_empty;
  logic                   w_stack_en;

  assign w_op      = r_ir[c_op_msb:c_op_lsb];
  assign w_cls     = op_class(w_op);
  assign w_pc_inc  = r_pc + PC_W'(1);
  assign w_target  = r_ir[PC_W-1:0];
  assign w_off     = r_ir[c_off_msb:c_off_lsb];
  assign w_branch  = r_pc + {{(PC_W-c_off_w){w_off[c_off_w-1]}}, w_off};
  assign w_illegal = (w_cls == CLS_ILLEGAL) ||
                     (!w_stack_en && ((w_op == c_op_call) || (w_op == c_op_ret)));

`ifdef CPU19_CALL_STACK_EN
  cpu19_ret_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (w_pc_inc),
    .o_top       (w_stk_top),
    .o_full      (w_stk_full),
    .o_empty     (w_stk_empty)
  );
  assign w_stack_en = 1'b1;
`else
  // No storage: report full and empty so a stray CALL/RET still traps
  assign w_stk_top   = '0;
  assign w_stk_full  = 1'b1;
  assign w_stk_empty = 1'b1;
  assign w_stack_en  = 1'b0;
  logic w_unused_stack;
  assign w_unused_stack = ^{w_push, w_pop, (STACK_DEPTH > 0)};
`endif

  // Outputs decoded straight from state so reset clears them without waiting for a clock
  assign imem_req  = (r_state == ST_FETCH);
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign dmem_req  = (r_state == ST_MEM);
  assign dmem_we   = (r_state == ST_MEM) && (w_op == c_op_st);
  assign halted    = (r_state == ST_HALTED);
  assign trap      = (r_state == ST_TRAP);
  assign issue_op  = r_ir[c_op_msb:c_op_lsb];
  assign issue_rd  = r_ir[c_rd_msb:c_rd_lsb];
  assign issue_rs1 = r_ir[c_rs1_msb:c_rs1_lsb];
  assign issue_rs2 = r_ir[c_rs2_msb:c_rs2_lsb];

  // State, PC and instruction register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc_next;
      if (w_ir_load) begin
        r_ir <= imem_rdata;
      end
    end
  end

  // Next state, PC update, issue strobe and stack control
  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    w_ir_load    = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    issue_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (run) w_next_state = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          w_ir_load    = 1'b1;
          w_next_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_next_state = w_illegal ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        case (w_cls)
          CLS_ALU: begin
            issue_valid  = 1'b1;
            w_pc_next    = w_pc_inc;
            w_next_state = ST_FETCH;
          end
          CLS_MULTI: begin
            issue_valid  = 1'b1;
            w_next_state = ST_WAIT_EX;
          end
          CLS_MEM:  w_next_state = ST_MEM;
          CLS_HALT: w_next_state = ST_HALTED;
          CLS_CTRL: begin
            w_next_state = ST_FETCH;
            case (w_op)
              c_op_jmp: w_pc_next = w_target;
              c_op_beq: w_pc_next = cmp_eq ? w_branch : w_pc_inc;
              c_op_bne: w_pc_next = cmp_eq ? w_pc_inc : w_branch;
              c_op_call: begin
                // Overflow traps with the PC left on the offending CALL
                if (w_stk_full) begin
                  w_next_state = ST_TRAP;
                end else begin
                  w_push    = 1'b1;
                  w_pc_next = w_target;
                end
              end
              c_op_ret: begin
                if (w_stk_empty) begin
                  w_next_state = ST_TRAP;
                end else begin
                  w_pop     = 1'b1;
                  w_pc_next = w_stk_top;
                end
              end
              default: w_next_state = ST_TRAP;
            endcase
          end
          default: w_next_state = ST_TRAP;
        endcase
      end
      ST_WAIT_EX: begin
        if (ex_done) begin
          w_pc_next    = w_pc_inc;
          w_next_state = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (dmem_ack) begin
          w_pc_next    = w_pc_inc;
          w_next_state = ST_FETCH;
        end
      end
      ST_HALTED: w_next_state = ST_HALTED;
      ST_TRAP:   w_next_state = ST_TRAP;
      default:   w_next_state = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu19_seq.sv
// ============================================================================
// Module      : tb_cpu19_seq
// Description : Directed self-checking bench for cpu19_seq. A small
//               instruction memory answers fetches; each scenario resets the
//               sequencer, loads a short program and checks cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cpu19_seq;

  localparam int PC_W = 14;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_INC  = 5'b00100;
  localparam logic [4:0] OP_JMP  = 5'b01010;
  localparam logic [4:0] OP_BEQ  = 5'b01011;
  localparam logic [4:0] OP_BNE  = 5'b01100;
  localparam logic [4:0] OP_CALL = 5'b01101;
  localparam logic [4:0] OP_RET  = 5'b01110;
  localparam logic [4:0] OP_LD   = 5'b01111;
  localparam logic [4:0] OP_ST   = 5'b10000;
  localparam logic [4:0] OP_HALT = 5'b11111;

  logic            clk       = 1'b0;
  logic            rst       = 1'b1;
  logic            run       = 1'b0;
  logic            ack_en    = 1'b1;
  logic            ex_done   = 1'b0;
  logic            cmp_eq    = 1'b0;
  logic            dmem_ack  = 1'b0;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [18:0]     imem_rdata;
  logic            issue_valid;
  logic [4:0]      issue_op;
  logic [3:0]      issue_rd;
  logic [3:0]      issue_rs1;
  logic [3:0]      issue_rs2;
  logic            dmem_req;
  logic            dmem_we;
  logic [PC_W-1:0] pc;
  logic            halted;
  logic            trap;

  logic [18:0]     mem [64];
  int              n_checks = 0;
  int              n_err    = 0;

  assign imem_ack   = imem_req & ack_en;
  assign imem_rdata = mem[imem_addr[5:0]];

  always #5 clk = ~clk;

  cpu19_seq #(.PC_W(PC_W), .STACK_DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .issue_valid (issue_valid),
    .issue_op    (issue_op),
    .issue_rd    (issue_rd),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .ex_done     (ex_done),
    .cmp_eq      (cmp_eq),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ack    (dmem_ack),
    .pc          (pc),
    .halted      (halted),
    .trap        (trap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] r_ins(input logic [4:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, rd, rs1, rs2, 2'b00};
  endfunction

  function automatic logic [18:0] j_ins(input logic [4:0] op, input logic [13:0] tgt);
    return {op, tgt};
  endfunction

  function automatic logic [18:0] b_ins(input logic [4:0] op, input logic [5:0] off);
    return {op, 8'h00, off};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset the DUT and refill program memory with HALT
  task automatic do_reset();
    rst      = 1'b0;
    run      = 1'b0;
    ack_en   = 1'b1;
    ex_done  = 1'b0;
    cmp_eq   = 1'b0;
    dmem_ack = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = j_ins(OP_HALT, 14'd0);
    step(2);
    rst = 1'b1;
    step(1);
  endtask

  // Pulse run; on return the DUT is in its first FETCH cycle
  task automatic start();
    run = 1'b1;
    step(1);
    run = 1'b0;
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_ctl",    {26'd0, imem_req, issue_valid, dmem_req, dmem_we, halted, trap}, 32'd0);
    chk("rst_pc",     {18'd0, pc}, 32'd0);
    chk("rst_addr",   {18'd0, imem_addr}, 32'd0);
    chk("rst_fields", {15'd0, issue_op, issue_rd, issue_rs1, issue_rs2}, 32'd0);
    do_reset();
    chk("idle_req", {31'd0, imem_req}, 32'd0);

    // ADD r0,r1,r2 with immediate ack, then HALT
    do_reset();
    mem[0] = r_ins(OP_ADD, 4'd0, 4'd1, 4'd2);
    start();
    chk("add_c1_req",  {31'd0, imem_req}, 32'd1);
    step(1);
    chk("add_c2_iv",   {31'd0, issue_valid}, 32'd0);
    step(1);
    chk("add_c3_iv",   {31'd0, issue_valid}, 32'd1);
    chk("add_fields",  {15'd0, issue_op, issue_rd, issue_rs1, issue_rs2}, {15'd0, 5'b00000, 4'd0, 4'd1, 4'd2});
    step(1);
    chk("add_next_addr", {18'd0, imem_addr}, 32'd1);
    chk("add_next_iv",   {31'd0, issue_valid}, 32'd0);
    step(3);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_pc",   {18'd0, pc}, 32'd1);
    step(2);
    chk("halt_noreq", {30'd0, imem_req, halted}, 32'd1);

    // SUB with one extra fetch wait cycle: issue moves to cycle 4
    do_reset();
    mem[0] = r_ins(OP_SUB, 4'd3, 4'd4, 4'd5);
    ack_en = 1'b0;
    start();
    step(1);
    chk("wait_hold_req", {31'd0, imem_req}, 32'd1);
    ack_en = 1'b1;
    step(2);
    chk("wait_c4_iv", {31'd0, issue_valid}, 32'd1);
    chk("wait_op",    {27'd0, issue_op}, 32'd1);
    step(1);
    chk("wait_pc", {18'd0, pc}, 32'd1);

    // MUL with ex_done 4 cycles after issue (spurious ex_done in issue cycle)
    do_reset();
    mem[0] = r_ins(OP_MUL, 4'd1, 4'd2, 4'd3);
    start();
    step(2);
    chk("mul_issue", {31'd0, issue_valid}, 32'd1);
    ex_done = 1'b1;
    step(1);
    ex_done = 1'b0;
    chk("mul_c4_iv",   {31'd0, issue_valid}, 32'd0);
    chk("mul_stable",  {15'd0, issue_op, issue_rd, issue_rs1, issue_rs2}, {15'd0, 5'b00010, 4'd1, 4'd2, 4'd3});
    step(2);
    chk("mul_c6_wait", {30'd0, imem_req, pc[0]}, 32'd0);
    step(1);
    ex_done = 1'b1;
    chk("mul_c7_pc", {18'd0, pc}, 32'd0);
    step(1);
    ex_done = 1'b0;
    chk("mul_c8_fetch", {17'd0, imem_req, imem_addr}, {17'd0, 1'b1, 14'd1});

    // JMP 5, then BEQ -2 taken
    do_reset();
    mem[0] = j_ins(OP_JMP, 14'd5);
    mem[5] = b_ins(OP_BEQ, 6'b111110);
    cmp_eq = 1'b1;
    start();
    step(3);
    chk("jmp_pc", {18'd0, pc}, 32'd5);
    step(3);
    chk("beq_taken_pc", {18'd0, pc}, 32'd3);

    // BNE with cmp_eq=1 falls through
    do_reset();
    mem[0] = j_ins(OP_JMP, 14'd5);
    mem[5] = b_ins(OP_BNE, 6'b111110);
    cmp_eq = 1'b1;
    start();
    step(6);
    chk("bne_fall_pc", {18'd0, pc}, 32'd6);

    // BNE taken backwards from 0 wraps to 16382
    do_reset();
    mem[0] = b_ins(OP_BNE, 6'b111110);
    start();
    step(3);
    chk("bne_wrap_pc", {18'd0, pc}, 32'd16382);

    // JMP to top of PC space, INC there wraps pc to 0
    do_reset();
    mem[0]  = j_ins(OP_JMP, 14'h3FFF);
    mem[63] = r_ins(OP_INC, 4'd0, 4'd0, 4'd0);
    start();
    step(3);
    chk("jmp_top_pc", {18'd0, pc}, 32'd16383);
    step(3);
    chk("inc_wrap_pc", {18'd0, pc}, 32'd0);

`ifdef CPU19_CALL_STACK_EN
    // CALL/RET, then nine nested CALLs overflow the 8-entry stack
    do_reset();
    mem[0]  = j_ins(OP_JMP, 14'd18);
    mem[18] = j_ins(OP_CALL, 14'd50);
    mem[50] = j_ins(OP_RET, 14'd0);
    for (int k = 0; k < 9; k++) mem[19+k] = j_ins(OP_CALL, 14'(20 + k));
    start();
    step(3);
    chk("stk_jmp_pc",  {18'd0, pc}, 32'd18);
    step(3);
    chk("stk_call_pc", {18'd0, pc}, 32'd50);
    step(3);
    chk("stk_ret_pc",  {18'd0, pc}, 32'd19);
    step(24);
    chk("stk_9th_pc",  {17'd0, trap, pc}, {17'd0, 1'b0, 14'd27});
    step(3);
    chk("stk_ovf_trap", {17'd0, trap, pc}, {17'd0, 1'b1, 14'd27});

    // RET on empty stack
    do_reset();
    mem[0] = j_ins(OP_RET, 14'd0);
    start();
    step(3);
    chk("ret_empty_trap", {17'd0, trap, pc}, {17'd0, 1'b1, 14'd0});
`else
    // Without the stack, CALL and RET are illegal and trap at decode
    do_reset();
    mem[0] = j_ins(OP_CALL, 14'd50);
    start();
    step(2);
    chk("call_ill_trap", {17'd0, trap, pc}, {17'd0, 1'b1, 14'd0});
    chk("call_ill_iv",   {31'd0, issue_valid}, 32'd0);
    do_reset();
    mem[0] = j_ins(OP_RET, 14'd0);
    start();
    step(2);
    chk("ret_ill_trap", {17'd0, trap, pc}, {17'd0, 1'b1, 14'd0});
`endif

    // Illegal opcode 10101
    do_reset();
    mem[0] = j_ins(5'b10101, 14'd0);
    start();
    step(1);
    chk("ill_dec_iv", {31'd0, issue_valid}, 32'd0);
    step(1);
    chk("ill_trap", {16'd0, trap, issue_valid, pc}, {16'd0, 1'b1, 1'b0, 14'd0});
    step(2);
    chk("ill_sticky", {30'd0, trap, imem_req}, 32'd2);

    // ST with one wait cycle on dmem_ack, then LD
    do_reset();
    mem[0] = r_ins(OP_ST, 4'd1, 4'd2, 4'd0);
    mem[1] = r_ins(OP_LD, 4'd3, 4'd2, 4'd0);
    start();
    step(3);
    chk("st_req", {30'd0, dmem_req, dmem_we}, 32'd3);
    step(1);
    chk("st_hold", {17'd0, dmem_req, pc}, {17'd0, 1'b1, 14'd0});
    dmem_ack = 1'b1;
    step(1);
    dmem_ack = 1'b0;
    chk("st_done", {17'd0, dmem_req, imem_addr}, {17'd0, 1'b0, 14'd1});
    step(3);
    chk("ld_req", {30'd0, dmem_req, dmem_we}, 32'd2);

    // Reset asserted in FETCH with an ack arriving
    do_reset();
    mem[0] = r_ins(OP_ADD, 4'd0, 4'd1, 4'd2);
    ack_en = 1'b0;
    start();
    step(1);
    chk("rr_fetch", {31'd0, imem_req}, 32'd1);
    #3;
    rst    = 1'b0;
    ack_en = 1'b1;
    #1;
    chk("rr_ctl_now", {26'd0, imem_req, issue_valid, dmem_req, dmem_we, halted, trap}, 32'd0);
    chk("rr_pc_now",  {18'd0, pc}, 32'd0);
    step(1);
    chk("rr_held", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    step(2);
    chk("rr_idle", {17'd0, imem_req, pc}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu19_seq.md
# cpu19_seq

Instruction sequencer for the 19-bit `cpu19` core. It owns the program counter and fetches instructions over a request/acknowledge port. It decodes each instruction and issues it to the ALU/register-file datapath, waits for multi-cycle units (MUL, DIV, ENC, DCR) and the data memory, and resolves JMP/BEQ/BNE/CALL/RET. It sits between instruction memory and the existing execute datapath, replacing direct instruction injection.

## Interface

**Parameters**
- `PC_W`, default 14: program-counter and jump-target width.
- `STACK_DEPTH`, default 8: number of return-address entries.

**Ports**
- `clk`, input, 1: the single clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `run`, input, 1: start execution from IDLE.
- `imem_req`, output, 1: instruction fetch request.
- `imem_addr`, output, PC_W: fetch address (equals `pc`).
- `imem_ack`, input, 1: fetch complete, `imem_rdata` valid.
- `imem_rdata`, input, 19: fetched instruction.
- `issue_valid`, output, 1: one-cycle strobe issuing an ALU/crypto op.
- `issue_op`, output, 5: opcode field of the issued instruction.
- `issue_rd` / `issue_rs1` / `issue_rs2`, output, 4 each: register fields.
- `ex_done`, input, 1: multi-cycle unit finished.
- `cmp_eq`, input, 1: datapath compare rs1==rs2, valid in EXEC.
- `dmem_req`, output, 1: data memory request.
- `dmem_we`, output, 1: 1 = ST, 0 = LD.
- `dmem_ack`, input, 1: data access complete.
- `pc`, output, PC_W: current instruction address.
- `halted`, output, 1: sticky; HALT executed.
- `trap`, output, 1: sticky; illegal opcode or stack fault.

## Operation

Instruction format:
- [18:14] opcode.
- [13:10] rd/ra.
- [9:6] rs1/rb.
- [5:2] rs2.
- JMP/CALL target is [PC_W-1:0].
- BEQ/BNE offset is [5:0], signed.

Opcode map:
- 00000–01001: ADD, SUB, MUL, DIV, INC, DEC, AND, OR, XOR, NOT.
- 01010: JMP.
- 01011: BEQ.
- 01100: BNE.
- 01101: CALL.
- 01110: RET.
- 01111: LD.
- 10000: ST.
- 10001: ENC.
- 10010: DCR.
- 11111: HALT.
- All other opcodes: illegal.

States:
- IDLE → FETCH when `run`=1.
- FETCH: hold `imem_req`=1 until `imem_ack`. Capture the instruction into IR on the ack cycle, then → DECODE.
- DECODE: classify. Illegal opcode → TRAP.
- EXEC:
  - Single-cycle ALU (ADD, SUB, INC, DEC, AND, OR, XOR, NOT): `issue_valid`=1, pc←pc+1, → FETCH.
  - Multi-cycle (MUL, DIV, ENC, DCR): `issue_valid`=1, → WAIT_EX.
  - LD/ST: → MEM.
  - JMP: pc←target.
  - BEQ: pc←pc+sext(off) if `cmp_eq`, else pc+1.
  - BNE: pc←pc+sext(off) if not `cmp_eq`, else pc+1.
  - CALL: push pc+1, pc←target.
  - RET: pop into pc.
  - HALT → HALTED.
- WAIT_EX: when `ex_done`, pc←pc+1 and → FETCH.
- MEM: hold `dmem_req` and `dmem_we` until `dmem_ack`, then pc+1 → FETCH.
- HALTED / TRAP: terminal until reset. `pc` holds the faulting/halting address.

Arithmetic and stack rules:
- PC arithmetic is modulo 2^PC_W: 2^PC_W−1 + 1 wraps to 0, and negative offsets wrap likewise.
- CALL on a full stack (STACK_DEPTH entries) → TRAP with no push.
- RET on an empty stack → TRAP.

## Timing

- Reset values: `pc`=0, state IDLE, stack empty, every output 0.
- Reset assertion clears all state immediately, mid-operation included. An ack arriving during or after reset is ignored.
- Latency for an ALU op with zero-wait ack: 3 cycles (FETCH, DECODE, EXEC).
- Each extra wait cycle on `imem_ack` adds 1 cycle.
- Multi-cycle ops take 3 + N cycles, where `ex_done` arrives N cycles after issue.
- `ex_done` is sampled only in WAIT_EX. An `ex_done` in the issue cycle is ignored; units must assert it at least 1 cycle later.
- `issue_*` fields are stable from DECODE through WAIT_EX. `issue_valid` is high exactly 1 cycle per issued op.
- `cmp_eq` is sampled only on the EXEC cycle of BEQ/BNE.
- `run` is ignored outside IDLE.

## Configuration

- `CPU19_CALL_STACK_EN` defined: the return stack is built and CALL/RET behave as in Operation.
- `CPU19_CALL_STACK_EN` undefined: no stack storage; CALL and RET decode as illegal → TRAP.

## Structure

- Package `cpu19_pkg` holds:
  - opcode constants;
  - the state enumeration;
  - instruction field bit positions;
  - an op-class function (alu, multi, mem, ctrl, halt, illegal).
- One sub-module, `cpu19_ret_stack`: a LIFO of STACK_DEPTH × PC_W entries with push, pop, full and empty. It is instantiated only under `CPU19_CALL_STACK_EN`.

## Test plan

- ADD r0,r1,r2 at pc 0 with immediate ack → `issue_valid` on cycle 3 with op=00000, rd=0, rs1=1, rs2=2; next `imem_addr`=1.
- MUL with `ex_done` 4 cycles after issue → no fetch until `ex_done`; pc advances 0→1 only then; total 7 cycles.
- BEQ off=−2 at pc 5, `cmp_eq`=1 → pc=3. BNE at pc 5, `cmp_eq`=1 → pc=6.
- JMP 18 → pc=18. CALL 50 at pc 18 → pc=50. RET → pc=19. Nine CALLs with depth 8 → `trap`=1, pc=address of the 9th CALL.
- Opcode 10101 → `trap`=1, no `issue_valid`. HALT → `halted`=1, `imem_req` stays 0.
- Reset dropped low during FETCH with `imem_ack` pending → all outputs 0 immediately, pc=0, state IDLE after release.
